// File: rtl/cpu_sequencer_pkg.sv
// rtl/cpu_sequencer_pkg.sv - shared state, opcode, ALU and PC-source encodings for the CPU sequencer
package cpu_sequencer_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_FAULT  = 3'd6;

  localparam logic [1:0] PC_INC    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SLT = 4'd5;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_ADDI = 4'd6;
  localparam logic [3:0] OP_ANDI = 4'd7;
  localparam logic [3:0] OP_ORI  = 4'd8;
  localparam logic [3:0] OP_XORI = 4'd9;
  localparam logic [3:0] OP_LW   = 4'd10;
  localparam logic [3:0] OP_SW   = 4'd11;
  localparam logic [3:0] OP_BEQ  = 4'd12;
  localparam logic [3:0] OP_BNE  = 4'd13;
  localparam logic [3:0] OP_J    = 4'd14;
  localparam logic [3:0] OP_JAL  = 4'd15;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       addr_sel;
    logic       ir_load;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       reg_write;
    logic       alu_src;
    logic [3:0] alu_op;
    logic       mem_to_reg;
    logic       link;
  } ctrl_t;

  // Register and immediate forms of the same operation share one ALU code.
  function automatic logic [3:0] alu_for(input logic [3:0] op);
    case (op)
      OP_SUB:           return ALU_SUB;
      OP_AND, OP_ANDI:  return ALU_AND;
      OP_OR,  OP_ORI:   return ALU_OR;
      OP_XOR, OP_XORI:  return ALU_XOR;
      OP_SLT:           return ALU_SLT;
      default:          return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/cpu_sequencer_mem_wdog.sv
// rtl/cpu_sequencer_mem_wdog.sv - memory stall watchdog, pulses timeout on the TIMEOUT-th unacked request cycle
module cpu_sequencer_mem_wdog #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic ack,
  output logic timeout
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

  logic [7:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 8'd0;
    end else if (req && !ack) begin
      count <= (count == 8'hFF) ? count : count + 8'd1;
    end else begin
      count <= 8'd0;
    end
  end

  // count holds prior stall cycles, so this fires on the stall cycle that reaches TIMEOUT; ack wins.
  assign timeout = req && !ack && (count >= LIMIT);

endmodule

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer with memory watchdog
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [3:0]  opcode,
  input  logic        alu_zero,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        ir_load,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        reg_write,
  output logic        alu_src,
  output logic [3:0]  alu_op,
  output logic        mem_to_reg,
  output logic        link,
  output logic [2:0]  state,
  output logic        fault,
  output logic [15:0] instret
);

  logic [2:0]  state_q, state_d;
  logic [15:0] instret_q;
  logic        retire;
  logic        timeout;
  ctrl_t       ctl;

  cpu_sequencer_mem_wdog #(.TIMEOUT(TIMEOUT)) u_mem_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (ctl.mem_req),
    .ack     (mem_ack),
    .timeout (timeout)
  );

  always_comb begin
    ctl        = '0;
    ctl.alu_op = ALU_ADD;
    state_d    = state_q;
    retire     = 1'b0;
    case (state_q)
      S_IDLE: if (run) state_d = S_FETCH;
      S_FETCH: begin
        ctl.mem_req = 1'b1;
        if (mem_ack) begin
          ctl.ir_load  = 1'b1;
          ctl.pc_write = 1'b1;
          state_d      = S_DECODE;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        case (opcode)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT: begin
            ctl.alu_op = alu_for(opcode);
            state_d    = S_WB;
          end
          OP_ADDI, OP_ANDI, OP_ORI, OP_XORI: begin
            ctl.alu_src = 1'b1;
            ctl.alu_op  = alu_for(opcode);
            state_d     = S_WB;
          end
          OP_LW, OP_SW: begin
            ctl.alu_src = 1'b1;
            state_d     = S_MEM;
          end
          OP_BEQ, OP_BNE: begin
            ctl.alu_op = ALU_SUB;
            // BEQ takes on zero, BNE on non-zero.
            if ((opcode == OP_BEQ) == alu_zero) begin
              ctl.pc_write = 1'b1;
              ctl.pc_src   = PC_BRANCH;
            end
            retire = 1'b1;
          end
          OP_J: begin
            ctl.pc_write = 1'b1;
            ctl.pc_src   = PC_JUMP;
            retire       = 1'b1;
          end
          default: begin
            ctl.pc_write  = 1'b1;
            ctl.pc_src    = PC_JUMP;
            ctl.reg_write = 1'b1;
            ctl.link      = 1'b1;
            retire        = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        ctl.mem_req  = 1'b1;
        ctl.addr_sel = 1'b1;
        ctl.mem_we   = (opcode == OP_SW);
        if (mem_ack) begin
          if (opcode == OP_SW) retire = 1'b1;
          else                 state_d = S_WB;
        end
      end
      S_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.mem_to_reg = (opcode == OP_LW);
        retire         = 1'b1;
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
    if (retire) state_d = run ? S_FETCH : S_IDLE;
    if (timeout) state_d = S_FAULT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      instret_q <= 16'd0;
    end else begin
      state_q <= state_d;
      if (retire) instret_q <= instret_q + 16'd1;
    end
  end

  assign mem_req    = ctl.mem_req;
  assign mem_we     = ctl.mem_we;
  assign addr_sel   = ctl.addr_sel;
  assign ir_load    = ctl.ir_load;
  assign pc_write   = ctl.pc_write;
  assign pc_src     = ctl.pc_src;
  assign reg_write  = ctl.reg_write;
  assign alu_src    = ctl.alu_src;
  assign alu_op     = ctl.alu_op;
  assign mem_to_reg = ctl.mem_to_reg;
  assign link       = ctl.link;
  assign state      = state_q;
  assign fault      = (state_q == S_FAULT);
  assign instret    = instret_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - scoreboard bench for cpu_sequencer
module tb_cpu_sequencer;
  import cpu_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, run, alu_zero, mem_ack;
  logic [3:0]  opcode;
  logic        mem_req, mem_we, addr_sel, ir_load, pc_write, reg_write, alu_src;
  logic        mem_to_reg, link, fault;
  logic [1:0]  pc_src;
  logic [3:0]  alu_op;
  logic [2:0]  state;
  logic [15:0] instret;
  logic [15:0] ctl_obs;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] exp_instret;

  typedef struct packed {
    logic        ack;
    logic [2:0]  st;
    logic [15:0] ctl;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  cpu_sequencer #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .alu_zero(alu_zero),
    .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
    .ir_load(ir_load), .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write),
    .alu_src(alu_src), .alu_op(alu_op), .mem_to_reg(mem_to_reg), .link(link),
    .state(state), .fault(fault), .instret(instret)
  );

  assign ctl_obs = {fault, mem_req, mem_we, addr_sel, ir_load, pc_write, pc_src,
                    reg_write, alu_src, alu_op, mem_to_reg, link};

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] cv(input logic req, we, asel, irl, pcw,
                                     input logic [1:0] src, input logic rw, asrc,
                                     input logic [3:0] aop, input logic m2r, lnk, flt);
    return {flt, req, we, asel, irl, pcw, src, rw, asrc, aop, m2r, lnk};
  endfunction

  function automatic logic [3:0] exp_alu(input logic [3:0] op);
    case (op)
      OP_ADD, OP_ADDI: return ALU_ADD;
      OP_SUB:          return ALU_SUB;
      OP_AND, OP_ANDI: return ALU_AND;
      OP_OR, OP_ORI:   return ALU_OR;
      OP_XOR, OP_XORI: return ALU_XOR;
      default:         return ALU_SLT;
    endcase
  endfunction

  task automatic push(input logic ack, input logic [2:0] st, input logic [15:0] ctl);
    sb.push_back({ack, st, ctl});
  endtask

  task automatic build(input logic [3:0] op, input int fw, input int mw, input logic z);
    logic tk;
    logic we;
    opcode   = op;
    alu_zero = z;
    for (int i = 0; i < fw; i++) push(1'b0, S_FETCH, cv(1,0,0,0,0,PC_INC,0,0,ALU_ADD,0,0,0));
    push(1'b1, S_FETCH, cv(1,0,0,1,1,PC_INC,0,0,ALU_ADD,0,0,0));
    push(1'b0, S_DECODE, cv(0,0,0,0,0,PC_INC,0,0,ALU_ADD,0,0,0));
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT: begin
        push(1'b0, S_EXEC, cv(0,0,0,0,0,PC_INC,0,0,exp_alu(op),0,0,0));
        push(1'b0, S_WB, cv(0,0,0,0,0,PC_INC,1,0,ALU_ADD,0,0,0));
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_XORI: begin
        push(1'b0, S_EXEC, cv(0,0,0,0,0,PC_INC,0,1,exp_alu(op),0,0,0));
        push(1'b0, S_WB, cv(0,0,0,0,0,PC_INC,1,0,ALU_ADD,0,0,0));
      end
      OP_LW, OP_SW: begin
        we = (op == OP_SW);
        push(1'b0, S_EXEC, cv(0,0,0,0,0,PC_INC,0,1,ALU_ADD,0,0,0));
        for (int i = 0; i < mw; i++) push(1'b0, S_MEM, cv(1,we,1,0,0,PC_INC,0,0,ALU_ADD,0,0,0));
        push(1'b1, S_MEM, cv(1,we,1,0,0,PC_INC,0,0,ALU_ADD,0,0,0));
        if (!we) push(1'b0, S_WB, cv(0,0,0,0,0,PC_INC,1,0,ALU_ADD,1,0,0));
      end
      OP_BEQ, OP_BNE: begin
        tk = (op == OP_BEQ) ? z : !z;
        push(1'b0, S_EXEC, cv(0,0,0,0,tk,tk ? PC_BRANCH : PC_INC,0,0,ALU_SUB,0,0,0));
      end
      OP_J:    push(1'b0, S_EXEC, cv(0,0,0,0,1,PC_JUMP,0,0,ALU_ADD,0,0,0));
      default: push(1'b0, S_EXEC, cv(0,0,0,0,1,PC_JUMP,1,0,ALU_ADD,0,1,0));
    endcase
    exp_instret = exp_instret + 16'd1;
  endtask

  task automatic drain(input int n);
    exp_t e;
    for (int i = 0; i < n && sb.size() > 0; i++) begin
      e = sb.pop_front();
      @(negedge clk);
      mem_ack = e.ack;
      #2;
      check_eq("state", 32'(state), 32'(e.st));
      check_eq("ctl", 32'(ctl_obs), 32'(e.ctl));
    end
  endtask

  task automatic issue(input logic [3:0] op, input int fw, input int mw, input logic z);
    build(op, fw, mw, z);
    drain(1000);
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    check_eq("instret", 32'(instret), 32'(exp_instret));
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; mem_ack = 1'b0; opcode = OP_ADD; alu_zero = 1'b0;
    exp_instret = 16'd0;
    repeat (2) @(negedge clk);
    #2;
    check_eq("rst_state", 32'(state), 32'(S_IDLE));
    check_eq("rst_ctl", 32'(ctl_obs), 32'd0);
    check_eq("rst_instret", 32'(instret), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    #2;
    check_eq("idle_hold", 32'(state), 32'(S_IDLE));
    run = 1'b1;

    issue(OP_ADDI, 0, 0, 1'b0);
    issue(OP_ADD,  1, 0, 1'b0);
    issue(OP_SUB,  0, 0, 1'b0);
    issue(OP_SLT,  3, 0, 1'b0);
    issue(OP_AND,  0, 0, 1'b0);
    issue(OP_XORI, 2, 0, 1'b0);
    issue(OP_LW,   0, 3, 1'b0);
    issue(OP_SW,   0, 0, 1'b0);
    issue(OP_BEQ,  0, 0, 1'b1);
    issue(OP_BNE,  0, 0, 1'b1);
    issue(OP_BNE,  0, 0, 1'b0);
    issue(OP_J,    0, 0, 1'b0);
    issue(OP_JAL,  1, 0, 1'b0);

    build(OP_SW, 0, 3, 1'b0);
    drain(4);
    sb.delete();
    #1 rst_n = 1'b0;
    #1;
    check_eq("abort_req", 32'(mem_req), 32'd0);
    check_eq("abort_we", 32'(mem_we), 32'd0);
    check_eq("abort_state", 32'(state), 32'(S_IDLE));
    check_eq("abort_instret", 32'(instret), 32'd0);
    exp_instret = 16'd0;
    mem_ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    issue(OP_ORI, 0, 0, 1'b0);
    #2 force dut.instret_q = 16'hFFFF;
    #1 release dut.instret_q;
    exp_instret = 16'hFFFF;
    run = 1'b0;
    issue(OP_J, 0, 0, 1'b0);
    check_eq("wrap_zero", 32'(instret), 32'd0);
    repeat (2) begin
      @(negedge clk);
      #2;
      check_eq("stop_idle", 32'(state), 32'(S_IDLE));
    end

    run = 1'b1;
    opcode = OP_ADD;
    for (int i = 0; i < 4; i++) push(1'b0, S_FETCH, cv(1,0,0,0,0,PC_INC,0,0,ALU_ADD,0,0,0));
    for (int i = 0; i < 3; i++) push(1'b1, S_FAULT, cv(0,0,0,0,0,PC_INC,0,0,ALU_ADD,0,0,1));
    drain(1000);
    run = 1'b0;
    mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    check_eq("fault_sticky", 32'(ctl_obs), 32'(cv(0,0,0,0,0,PC_INC,0,0,ALU_ADD,0,0,1)));
    rst_n = 1'b0;
    #1;
    check_eq("fault_rst_state", 32'(state), 32'(S_IDLE));
    check_eq("fault_rst_flag", 32'(fault), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle control sequencer for the 16-bit CPU. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB, and drives the datapath control lines per state. It sequences a single shared instruction/data memory port through a req/ack handshake, and a watchdog forces a sticky fault on a stalled memory. It sits between the instruction register and the datapath and retires one instruction per pass.

## Interface
- TIMEOUT, 15: max cycles mem_req may stay high without mem_ack before fault; legal range 1..255.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  enable; sampled only at instruction boundaries.
- opcode  in  4  IR[15:12]; valid from DECODE onward.
- alu_zero  in  1  ALU zero flag, valid in EXEC.
- mem_ack  in  1  memory access complete; meaningful only while mem_req=1.
- mem_req  out  1  memory access request.
- mem_we  out  1  write strobe, qualifies mem_req.
- addr_sel  out  1  memory address source: 0=PC, 1=ALU result.
- ir_load  out  1  load IR from memory read data.
- pc_write  out  1  update PC.
- pc_src  out  2  PC source: 00=PC+1, 01=branch target, 10=jump target.
- reg_write  out  1  register-file write enable.
- alu_src  out  1  ALU B operand: 0=register, 1=immediate.
- alu_op  out  4  ALU operation code.
- mem_to_reg  out  1  writeback source is memory data.
- link  out  1  writeback PC+1 into the link register (JAL).
- state  out  3  current state, for debug.
- fault  out  1  sticky memory-timeout fault.
- instret  out  16  count of retired instructions; wraps.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, FAULT.
- IDLE:
  - moves to FETCH when run=1; otherwise holds.
- FETCH:
  - Drives mem_req=1, addr_sel=0.
  - On mem_ack, pulses ir_load=1, pc_write=1 with pc_src=00, then goes to DECODE.
- DECODE:
  - Register read only; next state is EXEC.
- EXEC, by opcode:
  - ADD, SUB, AND, OR, XOR, SLT: alu_src=0, matching alu_op, then WB.
  - ADDI, ANDI, ORI, XORI: alu_src=1, matching alu_op, then WB.
  - LW, SW: alu_src=1, alu_op=ADD, then MEM.
  - BEQ/BNE: alu_op=SUB. If alu_zero=1 (BEQ) or alu_zero=0 (BNE), assert pc_write with pc_src=01. Retire.
  - J: pc_write=1, pc_src=10. Retire.
  - JAL: pc_write=1, pc_src=10, reg_write=1, link=1. Retire.
- MEM:
  - Drives mem_req=1, addr_sel=1; mem_we=1 for SW only.
  - On mem_ack: LW goes to WB; SW retires.
- WB:
  - reg_write=1 for one cycle; mem_to_reg=1 for LW only. Retire.
- Retire:
  - instret increments by 1, mod 2^16.
  - Next state is FETCH if run=1, else IDLE.
- Default alu_op is ADD. Every control output not listed for a state is 0.
- Watchdog:
  - Counts consecutive cycles with mem_req=1 and mem_ack=0.
  - Clears when mem_ack is sampled or when mem_req=0.
  - When the count reaches TIMEOUT, the FSM goes to FAULT.
- FAULT:
  - fault=1, all other controls 0.
  - Exits only via rst_n.
- mem_ack with mem_req=0 is ignored.

## Timing
- Reset (asynchronous):
  - state=IDLE; instret=0; fault=0; watchdog count=0; every output 0 except alu_op=ADD.
  - Takes effect mid-transaction as well; mem_req drops immediately.
- mem_req is held high until the cycle in which mem_ack=1. Zero-wait ack in the same cycle as the request is legal.
- ir_load, pc_write (FETCH) and MEM completion are combinational on mem_ack. No other output depends combinationally on inputs, except the branch decision on alu_zero.
- Cycle counts at zero wait, FETCH to retire inclusive:
  - R-type and I-type: 4.
  - LW: 5.
  - SW: 4.
  - BEQ, BNE, J, JAL: 3.
- Each wait cycle adds 1 to the FETCH or MEM phase.
- A timeout occurring in the same cycle as mem_ack does not fault; ack has priority.
- instret wraps from 0xFFFF to 0x0000 without flag.

## Structure
- State encodings (3-bit), pc_src codes, ALU codes and opcodes belong in the shared define header, together with the existing opcode and ALU definitions.
- One sub-module: mem_wdog.
  - Input: req/ack; output: timeout pulse.
  - Parameterised on TIMEOUT; 8-bit saturating counter.
- The FSM is one registered state, with combinational output decode from state and opcode.

## Test plan
- Reset, then run=1, ADDI with ack every cycle:
  - state sequence IDLE, FETCH, DECODE, EXEC, WB, FETCH.
  - alu_src=1 in EXEC; reg_write=1 for exactly 1 cycle.
  - instret=1.
- LW with mem_ack delayed 3 cycles in MEM:
  - mem_req held 4 cycles, addr_sel=1.
  - WB has mem_to_reg=1; total 8 cycles.
- BEQ with alu_zero=1, then BNE with alu_zero=1:
  - First: pc_write=1, pc_src=01.
  - Second: pc_write=0.
  - Each takes 3 cycles; instret advances by 2.
- TIMEOUT=4, mem_ack held 0 in FETCH:
  - fault=1 after 4 request cycles.
  - mem_req=0; FSM stays in FAULT regardless of a later ack or run, until rst_n.
- rst_n pulsed low during SW in MEM:
  - mem_req and mem_we drop asynchronously; state=IDLE; instret unchanged from 0 after reset.
- Preload instret=0xFFFF via 65535 J instructions, or a force, then one more retire:
  - instret=0x0000.
  - run=0 at that retire gives next state IDLE.
